mem_port_arbiter: RTL and testbench

Shares one unified memory port between the core's instruction-fetch path and its data load/store path. It grants one requester at a time and drives a single request/acknowledge memory interface. Returned read data is registered and handed back with a one-cycle done pulse, and a core stall is raised while any access is outstanding. It sits between Core's instruction/data memory ports and the single-ported memory model, with a bus-timeout error reported alongside `decode_error`.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/arb_timeout_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_IF, BUSY_D, DONE, ERR)
//   arb_sel_e   : which requester currently owns the memory port
//   ARB_TMO_W   : width of the bus-timeout counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ARB_TMO_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_IF = 3'd1,
        BUSY_D  = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } arb_state_e;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_D  = 1'b1
    } arb_sel_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// ---------------------------------------------------------------------------
// arb_timeout_counter
// Counts cycles a granted access has waited for mem_ack.
// Ports:
//   Clk      in  clock
//   Reset    in  asynchronous, active-high reset
//   clear    in  zero the count (asserted on every grant)
//   enable   in  advance the count by one this cycle
//   terminal out high while count == TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [ARB_TMO_W-1:0] TC_VALUE = ARB_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [ARB_TMO_W-1:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TC_VALUE);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one request/acknowledge memory port between instruction fetch and
// data load/store. One requester is granted at a time, data before fetch.
// Read data is registered and returned with a one-cycle done pulse; a bus
// timeout parks the arbiter in a sticky error state until Reset.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until its *_done pulse; the request is captured at grant and later changes
// are ignored. Toward memory, mem_req stays high with stable mem_* until
// mem_ack, which completes the access in the cycle it is seen.
//
// Ports:
//   Clk, Reset                 clock, async active-high reset
//   if_req/if_addr             fetch request and address
//   if_rdata/if_done           fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store)
//   d_rdata/d_done             load data and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   memory request side
//   mem_ack/mem_rdata          memory completion and read data
//   core_stall                 a request is outstanding
//   bus_error                  sticky timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        core_stall,
    output logic        bus_error
);

    arb_state_e  state;
    arb_state_e  state_nxt;
    arb_sel_e    sel_q;

    logic        grant_if;
    logic        grant_d;
    logic        rdata_cap;
    logic        tmo_clear;
    logic        tmo_en;
    logic        tmo_tc;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .terminal(tmo_tc)
    );

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        rdata_cap = 1'b0;
        tmo_clear = 1'b0;
        tmo_en    = 1'b0;
        mem_req   = 1'b0;
        if_done   = 1'b0;
        d_done    = 1'b0;
        bus_error = 1'b0;
        case (state)
            IDLE: begin
                // Data first: it belongs to the instruction the core already holds.
                if (d_req) begin
                    grant_d   = 1'b1;
                    tmo_clear = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    tmo_clear = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                mem_req = 1'b1;
                tmo_en  = ~mem_ack;
                // An ack on the terminal cycle still completes normally.
                if (mem_ack) begin
                    rdata_cap = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_tc) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                // Requests are not sampled here, giving the requester a cycle to drop req.
                if_done   = (sel_q == SEL_IF);
                d_done    = (sel_q == SEL_D);
                state_nxt = IDLE;
            end
            ERR: begin
                bus_error = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture and read-data registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sel_q      <= SEL_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant_d) begin
                sel_q   <= SEL_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else if (grant_if) begin
                sel_q   <= SEL_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
            // Stores also overwrite d_rdata; its contents are meaningless then.
            if (rdata_cap) begin
                if (state == BUSY_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign core_stall = (if_req & ~if_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    // Main instance (default timeout)
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, d_done, mem_req, mem_we, core_stall, bus_error;

    // Short-timeout instance
    logic        t_if_req, t_d_req, t_d_we, t_mem_ack;
    logic [31:0] t_if_addr, t_d_addr, t_d_wdata, t_mem_rdata;
    logic [31:0] t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
    logic        t_if_done, t_d_done, t_mem_req, t_mem_we, t_core_stall, t_bus_error;

    mem_port_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .core_stall(core_stall), .bus_error(bus_error)
    );

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
        .Clk(Clk), .Reset(Reset),
        .if_req(t_if_req), .if_addr(t_if_addr), .if_rdata(t_if_rdata), .if_done(t_if_done),
        .d_req(t_d_req), .d_we(t_d_we), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
        .d_rdata(t_d_rdata), .d_done(t_d_done),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata),
        .core_stall(t_core_stall), .bus_error(t_bus_error)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference memory
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_if_rd = '0;
    logic [31:0] last_d_rd  = '0;
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], 16'h5A5A};
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // One scenario on the main instance, starting in an idle cycle (c=0).
    // Expected timeline from plain arithmetic: first access starts c=1,
    // ack at start+lat-1, done at ack+1, next access starts at ack+3.
    // Requesters hold req through their done cycle and drop it after.
    // ------------------------------------------------------------------
    task automatic run_scn(input bit has_if, input logic [31:0] ia, input int il,
                           input bit has_d, input bit dwe, input logic [31:0] da,
                           input logic [31:0] dwd, input int dl, input bit noisy);
        logic [31:0] a_addr[2];
        logic [31:0] a_wd[2];
        logic [31:0] a_rd[2];
        bit          a_we[2];
        bit          a_isd[2];
        int          a_lat[2];
        int          a_st[2];
        int          a_ack[2];
        int          n, last, done_if, done_d, win;
        n = 0;
        done_if = -1;
        done_d = -1;
        if (has_d) begin
            a_addr[n] = da; a_we[n] = dwe; a_wd[n] = dwd; a_isd[n] = 1'b1; a_lat[n] = dl; n++;
        end
        if (has_if) begin
            a_addr[n] = ia; a_we[n] = 1'b0; a_wd[n] = '0; a_isd[n] = 1'b0; a_lat[n] = il; n++;
        end
        a_st[0] = 1;
        for (int i = 0; i < n; i++) begin
            a_ack[i] = a_st[i] + a_lat[i] - 1;
            if (i + 1 < n) a_st[i+1] = a_ack[i] + 3;
            if (a_isd[i]) done_d = a_ack[i] + 1;
            else done_if = a_ack[i] + 1;
            a_rd[i] = '0;
        end
        last = a_ack[n-1] + 1;
        if_addr = ia; d_we = dwe; d_addr = da; d_wdata = dwd;
        for (int c = 0; c <= last + 1; c++) begin
            if_req = has_if && (c <= done_if);
            d_req  = has_d && (c <= done_d);
            win = -1;
            for (int i = 0; i < n; i++)
                if (c >= a_st[i] && c <= a_ack[i]) win = i;
            // Granted requesters' inputs must be ignored once captured.
            if (noisy && c >= 1) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                if (has_if && c >= a_st[n-1]) if_addr = $urandom;
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (win >= 0 && c == a_ack[win]) begin
                mem_ack = 1'b1;
                if (a_we[win]) mem_model[a_addr[win]] = a_wd[win];
                else mem_rdata = mem_read(a_addr[win]);
                a_rd[win] = mem_rdata;
            end else if (noisy && win < 0) begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            #1;
            chk1("mem_req", mem_req, win >= 0);
            if (win >= 0) begin
                chk32("mem_addr", mem_addr, a_addr[win]);
                chk1("mem_we", mem_we, a_we[win]);
                if (a_isd[win]) chk32("mem_wdata", mem_wdata, a_wd[win]);
            end
            if (c == done_if) last_if_rd = a_rd[n-1];
            if (c == done_d) last_d_rd = a_rd[0];
            chk1("if_done", if_done, c == done_if);
            chk1("d_done", d_done, c == done_d);
            chk32("if_rdata", if_rdata, last_if_rd);
            chk32("d_rdata", d_rdata, last_d_rd);
            chk1("core_stall", core_stall, (has_if && c < done_if) || (has_d && c < done_d));
            chk1("bus_error", bus_error, 1'b0);
            tick();
        end
        if_req = 1'b0;
        d_req = 1'b0;
        mem_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------
    initial begin
        int sel;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        t_if_req = 0; t_if_addr = '0; t_d_req = 0; t_d_we = 0; t_d_addr = '0; t_d_wdata = '0;
        t_mem_ack = 0; t_mem_rdata = '0;

        repeat (2) @(posedge Clk);
        #1;
        chk1("rst mem_req", mem_req, 1'b0);
        chk1("rst mem_we", mem_we, 1'b0);
        chk32("rst mem_addr", mem_addr, 32'h0);
        chk32("rst mem_wdata", mem_wdata, 32'h0);
        chk32("rst if_rdata", if_rdata, 32'h0);
        chk32("rst d_rdata", d_rdata, 32'h0);
        chk1("rst if_done", if_done, 1'b0);
        chk1("rst d_done", d_done, 1'b0);
        chk1("rst bus_error", bus_error, 1'b0);
        chk1("rst core_stall", core_stall, 1'b0);
        chk1("rst t_bus_error", t_bus_error, 1'b0);
        chk1("rst t_mem_req", t_mem_req, 1'b0);
        Reset = 1'b0;
        tick();

        // Single fetch, ack in first busy cycle
        mem_model[32'h10] = 32'hE3A00001;
        run_scn(1'b1, 32'h10, 1, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0);
        // Simultaneous store + fetch, ack latency 2 each
        mem_model[32'h20] = 32'h600DF00D;
        run_scn(1'b1, 32'h20, 2, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 2, 1'b0);
        // Load with wait states, then a fetch (d_rdata must stay held)
        mem_model[32'h240] = 32'h12345678;
        run_scn(1'b0, 32'h0, 1, 1'b1, 1'b0, 32'h240, 32'h0, 5, 1'b0);
        run_scn(1'b1, 32'h200, 1, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0);

        // Reset in the middle of a data access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h244;
        tick();
        tick();
        #1;
        chk1("busy mem_req", mem_req, 1'b1);
        chk32("busy d_rdata", d_rdata, 32'h12345678);
        Reset = 1'b1;
        #1;
        chk1("async mem_req", mem_req, 1'b0);
        chk1("async d_done", d_done, 1'b0);
        chk32("async d_rdata", d_rdata, 32'h0);
        chk32("async if_rdata", if_rdata, 32'h0);
        chk32("async mem_addr", mem_addr, 32'h0);
        chk1("async bus_error", bus_error, 1'b0);
        chk1("async core_stall", core_stall, 1'b1);
        d_req = 1'b0;
        last_if_rd = '0;
        last_d_rd = '0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick();
        run_scn(1'b1, 32'h10, 3, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0);

        // Randomized traffic with input scrambling and stray acks
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 2);
            run_scn(sel != 1, {24'h0, 4'($urandom_range(0, 15)), 4'h0}, $urandom_range(1, 6),
                    sel != 0, 1'($urandom_range(0, 1)), {24'h0, 4'($urandom_range(0, 15)), 4'h0},
                    $urandom, $urandom_range(1, 6), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Timeout: 4 busy cycles without ack, then sticky error
        t_d_req = 1'b1; t_d_we = 1'b0; t_d_addr = 32'h300; t_if_addr = 32'h40;
        for (int c = 0; c <= 14; c++) begin
            t_if_req = (c >= 8);
            #1;
            chk1("tmo mem_req", t_mem_req, (c >= 1) && (c <= 4));
            chk1("tmo bus_error", t_bus_error, c >= 5);
            chk1("tmo d_done", t_d_done, 1'b0);
            chk1("tmo if_done", t_if_done, 1'b0);
            chk1("tmo core_stall", t_core_stall, 1'b1);
            tick();
        end
        t_d_req = 1'b0;
        t_if_req = 1'b0;
        Reset = 1'b1;
        #1;
        chk1("tmo rst bus_error", t_bus_error, 1'b0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick();

        // Ack in the terminal busy cycle completes normally
        t_d_addr = 32'h304;
        for (int c = 0; c <= 7; c++) begin
            t_d_req = (c <= 5);
            t_mem_ack = (c == 4);
            t_mem_rdata = (c == 4) ? 32'h0BADF00D : 32'hFFFFFFFF;
            #1;
            chk1("edge mem_req", t_mem_req, (c >= 1) && (c <= 4));
            chk1("edge d_done", t_d_done, c == 5);
            chk32("edge d_rdata", t_d_rdata, (c >= 5) ? 32'h0BADF00D : 32'h0);
            chk1("edge bus_error", t_bus_error, 1'b0);
            tick();
        end
        t_mem_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
